instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 124 ++++++++++++
 tb/tb_instr_fetch.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch: single-outstanding memory requests feeding a 2-entry {pc, instr} FIFO.
// Optional same-cycle bypass of returned data to decode when IF_BYPASS_EN is defined.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [5:0]  opcode,
    output logic [5:0]  func
);

    typedef enum logic [1:0] {RUN, WAIT, DROP} state_t;

    state_t      state_reg;
    logic [31:0] fetch_pc_reg;
    logic [31:0] issued_pc_reg;
    logic [31:0] fifo_pc_reg    [2];
    logic [31:0] fifo_instr_reg [2];
    logic        wr_ptr_reg;
    logic        rd_ptr_reg;
    logic [1:0]  count_reg;

    logic issue;
    logic resp;
    logic bypass;
    logic enq;
    logic pop;

    assign imem_req  = (state_reg == RUN) && !redirect && (count_reg != 2'd2);
    assign imem_addr = fetch_pc_reg;
    assign issue     = imem_req && imem_ready;

    // A response is only kept when it belongs to the current stream.
    assign resp = (state_reg == WAIT) && imem_rvalid && !redirect;

`ifdef IF_BYPASS_EN
    assign bypass = resp && (count_reg == 2'd0);
    assign enq    = resp && !(bypass && inst_ready);
`else
    assign bypass = 1'b0;
    assign enq    = resp;
`endif

    assign pop = (count_reg != 2'd0) && inst_ready && !redirect;

    always_comb begin
        inst_valid = 1'b0;
        inst       = 32'h0;
        inst_pc    = 32'h0;
        if (count_reg != 2'd0) begin
            inst_valid = 1'b1;
            inst       = fifo_instr_reg[rd_ptr_reg];
            inst_pc    = fifo_pc_reg[rd_ptr_reg];
        end else if (bypass) begin
            inst_valid = 1'b1;
            inst       = imem_rdata;
            inst_pc    = issued_pc_reg;
        end
    end

    assign opcode = inst[31:26];
    assign func   = inst[5:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= RUN;
            fetch_pc_reg  <= RESET_PC;
            issued_pc_reg <= RESET_PC;
            wr_ptr_reg    <= 1'b0;
            rd_ptr_reg    <= 1'b0;
            count_reg     <= 2'd0;
        end else begin
            if (redirect) begin
                fetch_pc_reg <= redirect_pc & 32'hFFFF_FFFC;
            end else if (issue) begin
                fetch_pc_reg  <= fetch_pc_reg + 32'd4;
                issued_pc_reg <= fetch_pc_reg;
            end

            // A response arriving with a redirect still retires the outstanding request.
            case (state_reg)
                RUN:     if (issue) state_reg <= WAIT;
                WAIT:    if (imem_rvalid) state_reg <= RUN;
                         else if (redirect) state_reg <= DROP;
                DROP:    if (imem_rvalid) state_reg <= RUN;
                default: state_reg <= RUN;
            endcase

            if (redirect) begin
                count_reg  <= 2'd0;
                wr_ptr_reg <= 1'b0;
                rd_ptr_reg <= 1'b0;
            end else begin
                if (enq) wr_ptr_reg <= ~wr_ptr_reg;
                if (pop) rd_ptr_reg <= ~rd_ptr_reg;
                count_reg <= count_reg + {1'b0, enq} - {1'b0, pop};
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (enq && !redirect && (wr_ptr_reg == 1'(gi))) begin
                    fifo_pc_reg[gi]    <= issued_pc_reg;
                    fifo_instr_reg[gi] <= imem_rdata;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: random memory/decode/redirect traffic scored against the
// expected sequential fetch stream, plus directed reset, redirect and wrap scenarios.
module tb_instr_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [5:0]  opcode;
    logic [5:0]  func;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_rvalid;
    logic [31:0] w_rdata;
    logic        w_valid;
    logic [31:0] w_inst;
    logic [31:0] w_pc;
    logic [5:0]  w_op;
    logic [5:0]  w_fn;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_issue;
    logic [31:0] exp_pop;

    bit          mem_manual = 1'b0;
    bit          mem_rand = 1'b0;
    logic        man_ready = 1'b0;
    logic        man_rvalid = 1'b0;
    logic [31:0] man_rdata = 32'h0;
    logic        auto_ready;
    logic        auto_rvalid;
    logic [31:0] auto_rdata;
    logic [31:0] pend_addr;
    logic        pend;
    int          pend_left;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign imem_ready  = mem_manual ? man_ready  : auto_ready;
    assign imem_rvalid = mem_manual ? man_rvalid : auto_rvalid;
    assign imem_rdata  = mem_manual ? man_rdata  : auto_rdata;

    instr_fetch u_dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc), .opcode(opcode), .func(func)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rst(rst),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ready(1'b1),
        .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
        .redirect(1'b0), .redirect_pc(32'h0),
        .inst_valid(w_valid), .inst_ready(1'b1),
        .inst(w_inst), .inst_pc(w_pc), .opcode(w_op), .func(w_fn)
    );

    // Memory model: in-order, latency 1..3 cycles in random mode, 1 cycle otherwise.
    always @(posedge clk) begin
        if (!rst || mem_manual) begin
            pend        <= 1'b0;
            auto_rvalid <= 1'b0;
            auto_ready  <= 1'b1;
        end else begin
            auto_rvalid <= 1'b0;
            auto_ready  <= mem_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (pend) begin
                if (pend_left == 1) begin
                    pend        <= 1'b0;
                    auto_rvalid <= 1'b1;
                    auto_rdata  <= word_of(pend_addr);
                end else begin
                    pend_left <= pend_left - 1;
                end
            end
            if (imem_req && imem_ready) begin
                if (!mem_rand || $urandom_range(0, 2) == 0) begin
                    auto_rvalid <= 1'b1;
                    auto_rdata  <= word_of(imem_addr);
                end else begin
                    pend      <= 1'b1;
                    pend_addr <= imem_addr;
                    pend_left <= $urandom_range(1, 2);
                end
            end
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            w_rvalid <= 1'b0;
        end else begin
            w_rvalid <= w_req;
            w_rdata  <= word_of(w_addr);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; mem_manual = 1'b0; mem_rand = 1'b0; redirect = 1'b0;
        redirect_pc = 32'h0; inst_ready = 1'b1; man_ready = 1'b0; man_rvalid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_issue = 32'h0;
        exp_pop   = 32'h0;
    endtask

    task automatic test_reset();
        do_reset();
        inst_ready = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_inst_valid got=%0h exp=0", inst_valid); end
        checks++; if (inst !== 32'h0) begin failures++; $display("FAIL reset_inst got=%08h exp=00000000", inst); end
        checks++; if (inst_pc !== 32'h0) begin failures++; $display("FAIL reset_inst_pc got=%08h exp=00000000", inst_pc); end
        checks++; if (opcode !== 6'h0 || func !== 6'h0) begin failures++; $display("FAIL reset_opcode_func got=%02h/%02h exp=00/00", opcode, func); end
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_fetch_pc got=%08h exp=00000000", imem_addr); end
        @(negedge clk);
        rst = 1'b1; inst_ready = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL first_req got=%0h/%08h exp=1/00000000", imem_req, imem_addr); end
        @(negedge clk);
        $display("test_reset done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_sequential();
        int last_issue;
        int pops;
        logic [31:0] w;
        logic exp_valid;
        last_issue = -1;
        pops = 0;
        do_reset();
        for (int cyc = 0; cyc < 24; cyc++) begin
            inst_ready = 1'b1;
            #1;
            if (imem_req && imem_ready) begin
                checks++; if (imem_addr !== exp_issue) begin failures++; $display("FAIL seq_issue_addr got=%08h exp=%08h", imem_addr, exp_issue); end
                if (last_issue >= 0) begin
                    checks++; if (cyc - last_issue != 2) begin failures++; $display("FAIL seq_issue_gap got=%0d exp=2", cyc - last_issue); end
                end
                last_issue = cyc;
                exp_issue += 32'd4;
            end
            if (imem_rvalid) begin
`ifdef IF_BYPASS_EN
                exp_valid = 1'b1;
`else
                exp_valid = 1'b0;
`endif
                checks++; if (inst_valid !== exp_valid) begin failures++; $display("FAIL seq_latency got=%0h exp=%0h", inst_valid, exp_valid); end
            end
            if (inst_valid && inst_ready) begin
                w = word_of(exp_pop);
                checks++;
                if (inst_pc !== exp_pop || inst !== w || opcode !== w[31:26] || func !== w[5:0]) begin
                    failures++; $display("FAIL seq_pop got=%08h:%08h exp=%08h:%08h", inst_pc, inst, exp_pop, w);
                end
                exp_pop += 32'd4;
                pops++;
            end
            @(negedge clk);
        end
        checks++; if (pops < 8) begin failures++; $display("FAIL seq_pop_count got=%0d exp>=8", pops); end
        $display("test_sequential done pops=%0d checks=%0d failures=%0d", pops, checks, failures);
    endtask

    task automatic test_backpressure();
        int pops;
        int issues;
        pops = 0;
        issues = 0;
        for (int cyc = 0; cyc < 22; cyc++) begin
            inst_ready = (cyc >= 10);
            #1;
            if (cyc == 9) begin
                checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL bp_full_req got=%0h exp=0", imem_req); end
                checks++; if (inst_valid !== 1'b1 || inst_pc !== exp_pop) begin failures++; $display("FAIL bp_head got=%0h/%08h exp=1/%08h", inst_valid, inst_pc, exp_pop); end
            end
            if (imem_req && imem_ready) begin
                checks++; if (imem_addr !== exp_issue) begin failures++; $display("FAIL bp_issue_addr got=%08h exp=%08h", imem_addr, exp_issue); end
                exp_issue += 32'd4;
                if (cyc >= 10) issues++;
            end
            if (inst_valid && inst_ready) begin
                checks++; if (inst_pc !== exp_pop || inst !== word_of(exp_pop)) begin failures++; $display("FAIL bp_pop got=%08h:%08h exp=%08h:%08h", inst_pc, inst, exp_pop, word_of(exp_pop)); end
                exp_pop += 32'd4;
                pops++;
            end
            @(negedge clk);
        end
        checks++; if (pops < 4 || issues < 2) begin failures++; $display("FAIL bp_drain got pops=%0d issues=%0d exp>=4/>=2", pops, issues); end
        $display("test_backpressure done pops=%0d checks=%0d failures=%0d", pops, checks, failures);
    endtask

    task automatic test_redirect();
        do_reset();
        mem_manual = 1'b1; man_ready = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL redir_first_issue got=%0h/%08h exp=1/00000000", imem_req, imem_addr); end
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL redir_req_blocked got=%0h exp=0", imem_req); end
        @(negedge clk);
        redirect = 1'b0;
        #1;
        checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("FAIL redir_flushed got=%0h/%0h exp=0/0", inst_valid, imem_req); end
        @(negedge clk);
        man_rvalid = 1'b1; man_rdata = word_of(32'h0);
        #1;
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL redir_stale_visible got=%0h exp=0", inst_valid); end
        @(negedge clk);
        man_rvalid = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0100) begin failures++; $display("FAIL redir_new_addr got=%0h/%08h exp=1/00000100", imem_req, imem_addr); end
        @(negedge clk);
        man_ready = 1'b0; man_rvalid = 1'b1; man_rdata = word_of(32'h0000_0100); inst_ready = 1'b0;
        @(negedge clk);
        man_rvalid = 1'b0;
        #1;
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0000_0100 || inst !== word_of(32'h0000_0100)) begin
            failures++; $display("FAIL redir_new_inst got=%0h/%08h:%08h exp=1/00000100:%08h", inst_valid, inst_pc, inst, word_of(32'h0000_0100));
        end
        @(negedge clk);
        $display("test_redirect done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_random_stream();
        int pops;
        int coincide;
        logic [31:0] w;
        pops = 0;
        coincide = 0;
        do_reset();
        mem_rand = 1'b1;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            inst_ready = ($urandom_range(0, 3) != 0);
            redirect = ($urandom_range(0, 14) == 0) || (imem_rvalid && ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | $urandom_range(0, 15);
            else redirect_pc = $urandom;
            #1;
            if (imem_req && imem_ready) begin
                checks++; if (imem_addr !== exp_issue) begin failures++; $display("FAIL rnd_issue_addr cyc=%0d got=%08h exp=%08h", cyc, imem_addr, exp_issue); end
                exp_issue += 32'd4;
            end
            if (inst_valid && inst_ready && !redirect) begin
                w = word_of(exp_pop);
                checks++;
                if (inst_pc !== exp_pop || inst !== w || opcode !== w[31:26] || func !== w[5:0]) begin
                    failures++; $display("FAIL rnd_pop cyc=%0d got=%08h:%08h exp=%08h:%08h", cyc, inst_pc, inst, exp_pop, w);
                end
                exp_pop += 32'd4;
                pops++;
            end
            if (redirect) begin
                if (imem_rvalid && inst_ready) coincide++;
                exp_issue = redirect_pc & 32'hFFFF_FFFC;
                exp_pop   = redirect_pc & 32'hFFFF_FFFC;
            end
            @(negedge clk);
        end
        redirect = 1'b0;
        checks++; if (pops < 100 || coincide < 1) begin failures++; $display("FAIL rnd_activity got pops=%0d coincide=%0d exp>=100/>=1", pops, coincide); end
        $display("test_random_stream done pops=%0d coincide=%0d checks=%0d failures=%0d", pops, coincide, checks, failures);
    endtask

    task automatic test_wrap();
        logic [31:0] wexp;
        int issues;
        wexp = 32'hFFFF_FFF8;
        issues = 0;
        do_reset();
        for (int cyc = 0; cyc < 10; cyc++) begin
            #1;
            if (w_req) begin
                checks++; if (w_addr !== wexp) begin failures++; $display("FAIL wrap_addr got=%08h exp=%08h", w_addr, wexp); end
                wexp += 32'd4;
                issues++;
            end
            @(negedge clk);
        end
        checks++; if (issues < 4) begin failures++; $display("FAIL wrap_issue_count got=%0d exp>=4", issues); end
        $display("test_wrap done issues=%0d checks=%0d failures=%0d", issues, checks, failures);
    endtask

    task automatic test_reset_mid();
        do_reset();
        mem_manual = 1'b1; man_ready = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL rmid_issue got=%0h/%08h exp=1/00000000", imem_req, imem_addr); end
        @(negedge clk);
        man_ready = 1'b0; rst = 1'b0;
        #1;
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rmid_in_reset got=%0h exp=0", inst_valid); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL rmid_release_req got=%0h/%08h exp=1/00000000", imem_req, imem_addr); end
        @(negedge clk);
        man_rvalid = 1'b1; man_rdata = 32'hDEAD_BEEF;
        #1;
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rmid_stale_cycle got=%0h exp=0", inst_valid); end
        @(negedge clk);
        man_rvalid = 1'b0; man_ready = 1'b1;
        #1;
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rmid_stale_ignored got=%0h exp=0", inst_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL rmid_refetch got=%0h/%08h exp=1/00000000", imem_req, imem_addr); end
        @(negedge clk);
        man_ready = 1'b0; man_rvalid = 1'b1; man_rdata = word_of(32'h0); inst_ready = 1'b0;
        @(negedge clk);
        man_rvalid = 1'b0;
        #1;
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== word_of(32'h0)) begin
            failures++; $display("FAIL rmid_fresh got=%0h/%08h:%08h exp=1/00000000:%08h", inst_valid, inst_pc, inst, word_of(32'h0));
        end
        @(negedge clk);
        $display("test_reset_mid done checks=%0d failures=%0d", checks, failures);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_random_stream();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
